// File: rtl/fifo_write_arbiter_pkg.sv
// rtl/fifo_write_arbiter_pkg.sv - shared state encoding and tag-width helper
package fifo_write_arbiter_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      LOCK = 1'b1
   } state_t;

   // Smallest width able to index n sources, never less than one bit.
   function automatic int tag_width(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w = w + 1;
      return w;
   endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// rtl/fifo_write_arbiter_rr_pick.sv - combinational round-robin selector
module rr_pick
   import fifo_write_arbiter_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int TAG_WIDTH = tag_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0]   req,
   input  logic [TAG_WIDTH-1:0] last_grant,
   output logic [TAG_WIDTH-1:0] winner,
   output logic                 any_req
);

   int idx;

   // Search starts one past the previous winner so it gets lowest priority.
   always_comb begin
      winner  = '0;
      any_req = 1'b0;
      idx     = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (int'(last_grant) + k) % NUM_REQ;
         if (!any_req && req[idx]) begin
            any_req = 1'b1;
            winner  = TAG_WIDTH'(idx);
         end
      end
   end

endmodule

// File: rtl/fifo_write_arbiter.sv
// rtl/fifo_write_arbiter.sv - packet-locked round-robin arbiter for a FIFO write port
module fifo_write_arbiter
   import fifo_write_arbiter_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int DAT_WIDTH = 16,
   parameter int TAG_WIDTH = tag_width(NUM_REQ)
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [NUM_REQ*DAT_WIDTH-1:0]   req_data,
   input  logic [NUM_REQ-1:0]             req_last,
   output logic [NUM_REQ-1:0]             req_ready,
   output logic                           out_valid,
   output logic [DAT_WIDTH-1:0]           out_data,
   output logic [TAG_WIDTH-1:0]           out_tag,
   output logic                           out_last,
   input  logic                           out_ready,
   output logic [TAG_WIDTH-1:0]           grant_id,
   output logic                           busy
);

   state_t                state, state_next;
   logic [TAG_WIDTH-1:0]  grant_next;
   logic [TAG_WIDTH-1:0]  last_grant, last_next;
   logic [TAG_WIDTH-1:0]  pick_winner;
   logic                  pick_any;
   logic                  sel_valid, sel_last;
   logic [DAT_WIDTH-1:0]  sel_data;
   logic                  load_ok, accept;

   rr_pick #(
      .NUM_REQ   (NUM_REQ),
      .TAG_WIDTH (TAG_WIDTH)
   ) u_rr_pick (
      .req        (req_valid),
      .last_grant (last_grant),
      .winner     (pick_winner),
      .any_req    (pick_any)
   );

   assign busy    = (state == LOCK);
   assign load_ok = !out_valid || out_ready;
   assign accept  = busy && load_ok && sel_valid;

   always_comb begin
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      sel_data  = '0;
      req_ready = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_id == TAG_WIDTH'(i)) begin
            sel_valid    = req_valid[i];
            sel_last     = req_last[i];
            sel_data     = req_data[i*DAT_WIDTH +: DAT_WIDTH];
            req_ready[i] = busy && load_ok;
         end
      end
   end

   always_comb begin
      state_next = state;
      grant_next = grant_id;
      last_next  = last_grant;
      case (state)
         IDLE: begin
            if (pick_any) begin
               state_next = LOCK;
               grant_next = pick_winner;
            end
         end
         LOCK: begin
            if (accept && sel_last) begin
               state_next = IDLE;
               last_next  = grant_id;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         grant_id   <= '0;
         last_grant <= TAG_WIDTH'(NUM_REQ - 1);
      end else begin
         state      <= state_next;
         grant_id   <= grant_next;
         last_grant <= last_next;
      end
   end

   // Loading while draining keeps one beat per clock; otherwise hold until taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_tag   <= '0;
         out_last  <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_data  <= sel_data;
         out_tag   <= grant_id;
         out_last  <= sel_last;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb/tb_fifo_write_arbiter.sv - directed self-checking bench for fifo_write_arbiter
module tb_fifo_write_arbiter;

   localparam int NR = 4;
   localparam int DW = 16;
   localparam int TW = 2;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [NR-1:0]   req_valid;
   logic [NR*DW-1:0] req_data;
   logic [NR-1:0]   req_last;
   logic [NR-1:0]   req_ready;
   logic            out_valid;
   logic [DW-1:0]   out_data;
   logic [TW-1:0]   out_tag;
   logic            out_last;
   logic            out_ready;
   logic [TW-1:0]   grant_id;
   logic            busy;

   int checks = 0;
   int errors = 0;

   fifo_write_arbiter #(.NUM_REQ(NR), .DAT_WIDTH(DW), .TAG_WIDTH(TW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_last  (req_last),
      .req_ready (req_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_tag   (out_tag),
      .out_last  (out_last),
      .out_ready (out_ready),
      .grant_id  (grant_id),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_src(input int i, input logic v, input logic [DW-1:0] d, input logic l);
      req_valid[i]         = v;
      req_data[i*DW +: DW] = d;
      req_last[i]          = l;
   endtask

   task automatic chk_out(input string tag, input int v, input int d, input int t, input int l);
      chk({tag, "_valid"}, 32'(out_valid), v);
      chk({tag, "_data"},  32'(out_data),  d);
      chk({tag, "_tag"},   32'(out_tag),   t);
      chk({tag, "_last"},  32'(out_last),  l);
   endtask

   task automatic chk_ctl(input string tag, input int b, input int g, input int r);
      chk({tag, "_busy"},  32'(busy),      b);
      chk({tag, "_grant"}, 32'(grant_id),  g);
      chk({tag, "_ready"}, 32'(req_ready), r);
   endtask

   int src_idx, exp_idx, cyc;
   logic tog, src_take, out_take;

   initial begin
      rst_n = 1'b0; req_valid = '0; req_data = '0; req_last = '0; out_ready = 1'b1;
      tick(); tick();
      chk_ctl("rst", 0, 0, 0);
      chk_out("rst", 0, 0, 0, 0);
      rst_n = 1'b1;

      // Sources 0 and 2 start 3-beat packets together; 0 has first priority.
      set_src(0, 1, 16'hA0, 0); set_src(2, 1, 16'hC0, 0); #1;
      chk_ctl("t1_idle", 0, 0, 0);
      tick(); chk_ctl("t1_lock0", 1, 0, 1);
      tick(); set_src(0, 1, 16'hA1, 0); #1; chk_out("t1_a0", 1, 'hA0, 0, 0);
      tick(); set_src(0, 1, 16'hA2, 1); #1; chk_out("t1_a1", 1, 'hA1, 0, 0);
      tick(); set_src(0, 0, 16'h0, 0); #1; chk_out("t1_a2", 1, 'hA2, 0, 1);
      chk_ctl("t1_gap", 0, 0, 0);
      tick(); chk_ctl("t1_lock2", 1, 2, 4); chk("t1_drain", 32'(out_valid), 0);
      tick(); set_src(2, 1, 16'hC1, 0); #1; chk_out("t1_c0", 1, 'hC0, 2, 0);
      tick(); set_src(2, 1, 16'hC2, 1); #1; chk_out("t1_c1", 1, 'hC1, 2, 0);
      tick(); set_src(2, 0, 16'h0, 0); #1; chk_out("t1_c2", 1, 'hC2, 2, 1);
      chk("t1_end_busy", 32'(busy), 0);
      tick(); chk("t1_empty", 32'(out_valid), 0);

      // Fresh reset, then all four sources offer single-beat packets.
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      for (int i = 0; i < NR; i++) set_src(i, 1, DW'(16'h10 + i), 1);
      for (int k = 0; k < 5; k++) begin
         tick(); chk_ctl($sformatf("t2_lock%0d", k), 1, k % NR, 1 << (k % NR));
         chk($sformatf("t2_gapout%0d", k), 32'(out_valid), 0);
         tick(); chk_out($sformatf("t2_beat%0d", k), 1, 'h10 + (k % NR), k % NR, 1);
         chk($sformatf("t2_idle%0d", k), 32'(busy), 0);
      end
      req_valid = '0; req_last = '0;
      tick();

      // Source 1 four-beat packet with backpressure after beat 2.
      set_src(1, 1, 16'h31, 0);
      tick(); chk_ctl("t3_lock", 1, 1, 2);
      tick(); set_src(1, 1, 16'h32, 0); #1; chk_out("t3_b1", 1, 'h31, 1, 0);
      tick(); set_src(1, 1, 16'h33, 0); out_ready = 1'b0; #1;
      chk_out("t3_b2", 1, 'h32, 1, 0);
      chk_ctl("t3_stall0", 1, 1, 0);
      for (int k = 0; k < 5; k++) begin
         tick();
         chk_out($sformatf("t3_hold%0d", k), 1, 'h32, 1, 0);
         chk_ctl($sformatf("t3_hctl%0d", k), 1, 1, 0);
      end
      out_ready = 1'b1; #1; chk_ctl("t3_release", 1, 1, 2);
      tick(); set_src(1, 1, 16'h34, 1); #1; chk_out("t3_b3", 1, 'h33, 1, 0);
      tick(); set_src(1, 0, 16'h0, 0); #1; chk_out("t3_b4", 1, 'h34, 1, 1);
      chk("t3_idle", 32'(busy), 0);
      tick(); chk("t3_empty", 32'(out_valid), 0);

      // Source 3 wins (search from 2), gaps mid-packet while source 0 waits.
      set_src(3, 1, 16'h41, 0); set_src(0, 1, 16'h50, 1);
      tick(); chk_ctl("t4_lock3", 1, 3, 8);
      tick(); set_src(3, 0, 16'h0, 0); #1; chk_out("t4_b1", 1, 'h41, 3, 0);
      chk_ctl("t4_gap_ctl", 1, 3, 8);
      for (int k = 0; k < 3; k++) begin
         tick(); chk_ctl($sformatf("t4_gap%0d", k), 1, 3, 8);
      end
      set_src(3, 1, 16'h42, 1);
      tick(); set_src(3, 0, 16'h0, 0); #1; chk_out("t4_b2", 1, 'h42, 3, 1);
      chk("t4_idle", 32'(busy), 0);
      tick(); chk_ctl("t4_lock0", 1, 0, 1);
      tick(); set_src(0, 0, 16'h0, 0); #1; chk_out("t4_s0", 1, 'h50, 0, 1);
      tick();

      // Asynchronous reset while locked with a beat held in the output stage.
      set_src(2, 1, 16'h60, 0);
      tick(); chk_ctl("t5_lock2", 1, 2, 4);
      tick(); chk_out("t5_loaded", 1, 'h60, 2, 0);
      set_src(1, 1, 16'h71, 1);
      rst_n = 1'b0; #1;
      chk_ctl("t5_rst", 0, 0, 0);
      chk("t5_rst_valid", 32'(out_valid), 0);
      tick(); rst_n = 1'b1; set_src(2, 0, 16'h0, 0); set_src(1, 1, 16'h71, 1); set_src(2, 1, 16'h62, 0);
      tick(); chk_ctl("t5_lock1", 1, 1, 2);
      tick(); set_src(1, 0, 16'h0, 0); set_src(2, 0, 16'h0, 0); #1;
      chk_out("t5_b", 1, 'h71, 1, 1);
      tick(); tick();

      // Source 2 streams 8 beats while out_ready toggles every cycle.
      src_idx = 0; exp_idx = 0; tog = 1'b0;
      for (cyc = 0; cyc < 60 && exp_idx < 8; cyc++) begin
         tog = ~tog;
         out_ready = tog;
         set_src(2, src_idx < 8, DW'(16'h80 + src_idx), src_idx == 7);
         #1;
         src_take = req_valid[2] && req_ready[2];
         out_take = out_valid && out_ready;
         if (out_take) begin
            chk($sformatf("t6_data%0d", exp_idx), 32'(out_data), 'h80 + exp_idx);
            chk($sformatf("t6_tag%0d", exp_idx),  32'(out_tag), 2);
            chk($sformatf("t6_last%0d", exp_idx), 32'(out_last), 32'(exp_idx == 7));
            exp_idx++;
         end
         tick();
         if (src_take) src_idx++;
      end
      chk("t6_count", exp_idx, 8);
      set_src(2, 0, 16'h0, 0); out_ready = 1'b1;
      tick();
      chk("t6_empty", 32'(out_valid), 0);
      chk("t6_idle", 32'(busy), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Shares the write port of one clock-crossing FIFO between NUM_REQ packet sources in the FIFO's write clock domain.
- Round-robin grant, locked for a whole packet (held until the beat flagged last is accepted).
- Each accepted beat is registered together with its source tag and last flag, so the read side can demultiplex.
- Output handshake is ready/valid: out_ready connects to the FIFO's wdata_ready and out_valid to its wdata_valid.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DAT_WIDTH, 16, payload width per beat.
- TAG_WIDTH, 2, source-index width; must satisfy 2**TAG_WIDTH >= NUM_REQ.

Ports:
- clk  in  1  write-domain clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-source beat valid.
- req_data  in  NUM_REQ*DAT_WIDTH  per-source payload; source i occupies bits [i*DAT_WIDTH +: DAT_WIDTH].
- req_last  in  NUM_REQ  per-source end-of-packet flag, qualified by req_valid.
- req_ready  out  NUM_REQ  per-source accept; at most one bit high per cycle.
- out_valid  out  1  registered beat available.
- out_data  out  DAT_WIDTH  registered payload.
- out_tag  out  TAG_WIDTH  source index of the registered beat.
- out_last  out  1  registered end-of-packet flag.
- out_ready  in  1  downstream accept (FIFO not full).
- grant_id  out  TAG_WIDTH  currently locked source; valid while busy.
- busy  out  1  high in state LOCK.

Behaviour:
- Reset (async assert, sync deassert handled externally):
  - state=IDLE, out_valid=0, out_data=0, out_tag=0, out_last=0.
  - req_ready=0, busy=0, grant_id=0.
  - last_grant=NUM_REQ-1, so source 0 has first priority.
- States: IDLE, LOCK.
- IDLE:
  - If any req_valid, pick the first asserted source searching upward from last_grant+1, wrapping modulo NUM_REQ.
  - Next cycle: state=LOCK, grant_id=winner.
  - req_ready is all-zero in IDLE; arbitration costs exactly one cycle per packet.
- LOCK:
  - Output stage may load when load_ok = !out_valid | out_ready.
  - req_ready[grant_id]=load_ok; all other req_ready bits are 0.
  - Beat accepted when req_valid[grant_id] & req_ready[grant_id]. On acceptance: out_data/out_tag/out_last load next edge and out_valid=1.
  - Accepted beat with req_last=1: state=IDLE and last_grant=grant_id on the same edge.
  - Gaps (req_valid low) inside a packet are legal; the grant is held indefinitely with no timeout.
  - Valid requests from other sources are ignored until the lock is released.
- Output register:
  - Cleared (out_valid=0) when out_ready & out_valid and no new load.
  - Load and drain in the same cycle gives back-to-back beats at full throughput.
  - out_* stay stable while out_valid & !out_ready.
- Latency: req_valid seen in cycle 0 (IDLE) -> req_ready in cycle 1 -> out_valid in cycle 2. Steady state is one beat per clock while out_ready=1.
- Single-beat packet (req_last on the first beat): returns to IDLE after one accepted beat; the next grant is re-arbitrated.
- Downstream full (out_ready=0 with out_valid=1): req_ready=0 and the lock is held; no data is lost or duplicated.
- Round-robin wrap: grant after source NUM_REQ-1 searches from 0.
- Only one requester active: it is regranted each packet with one idle cycle between packets.
- Reset mid-packet: the packet is abandoned and the output register is cleared. The partial packet already in the FIFO is the downstream's responsibility (the tag and missing last let it discard).
- Source tag widths: out_tag is the zero-extended grant index.

Decomposition:
- Shared package holds the state encoding (IDLE=1'b0, LOCK=1'b1) and the TAG_WIDTH derivation helper (log2 function shared with the FIFO wrapper).
- One natural sub-module: rr_pick. Combinational round-robin selector taking the request vector and last_grant, returning winner index and any_req. Reused by the read-side demux arbiter.
- Output register stays in the top.

Test Plan:
- Reset, then sources 0 and 2 each present a 3-beat packet in the same cycle -> source 0 wins. out_tag=0 for beats A0..A2 (out_last on A2), then one idle cycle, then tag=2 beats C0..C2; busy low for exactly one cycle between packets.
- All 4 sources continuously request 1-beat packets with out_ready=1 -> grant order 0,1,2,3,0,1… and an accepted beat every second cycle.
- Source 1 sends a 4-beat packet, out_ready held low for 5 cycles after beat 2 -> out_data frozen at beat 2, req_ready[1]=0. After release, beats 3 and 4 follow back-to-back with no duplicates.
- Source 3 drops req_valid for 3 cycles mid-packet while source 0 requests -> grant_id stays 3 and req_ready[0]=0 throughout. Source 0 is granted only after source 3's last beat.
- rst_n asserted while locked with out_valid=1 -> out_valid, req_ready and busy drop to 0 immediately (asynchronously). The first grant after reset goes to the lowest-index valid source.
- Source 2 streams 8-beat packets at full rate with out_ready toggling every cycle -> every beat appears exactly once in order with out_tag=2, and out_last only on beat 8.
